// File: rtl/instr_fetch_unit_if.sv
// Bundle between the fetch unit, instruction memory, execute (redirect) and decode.
// Valid/ready semantics: a transfer happens in a cycle where the source holds
// valid (Imem_Req / Inst_Valid) high and the sink has ack/ready (Imem_Ack /
// Inst_Ready) high. Once raised, valid and its payload stay stable until that
// transfer, unless a redirect flushes the decode side.
interface instr_fetch_unit_if;
  logic        Redirect_Valid;
  logic [31:0] Redirect_PC;
  logic        Imem_Req;
  logic [31:0] Imem_Addr;
  logic        Imem_Ack;
  logic [31:0] Imem_Data;
  logic        Inst_Valid;
  logic [31:0] Inst_Out;
  logic [31:0] Inst_PC;
  logic        Inst_Ready;

  modport master (
    input  Redirect_Valid, Redirect_PC, Imem_Ack, Imem_Data, Inst_Ready,
    output Imem_Req, Imem_Addr, Inst_Valid, Inst_Out, Inst_PC
  );

  modport slave (
    output Redirect_Valid, Redirect_PC, Imem_Ack, Imem_Data, Inst_Ready,
    input  Imem_Req, Imem_Addr, Inst_Valid, Inst_Out, Inst_PC
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch unit: owns the fetch PC, one outstanding imem request, prefetch FIFO to decode.
// Define IFU_PERF_EN to add the Fetch_Count / Flush_Count performance counters.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                 Clk,
  input  logic                 Reset,
  instr_fetch_unit_if.master   bus,
  output logic [1:0]           dbg_state_o
`ifdef IFU_PERF_EN
  ,output logic [31:0]         Fetch_Count
  ,output logic [31:0]         Flush_Count
`endif
);
  localparam int          AW  = $clog2(FIFO_DEPTH);
  localparam int          CW  = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DISCARD = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   addr_q, addr_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   pc_mem   [FIFO_DEPTH];
  logic [31:0]   data_mem [FIFO_DEPTH];
  logic          inst_valid, pop, push;
  logic          unused_redirect_lsb;

  assign unused_redirect_lsb = ^bus.Redirect_PC[1:0];
  assign inst_valid          = (count_q != '0);

  // Redirect cancels any same-cycle pop or push; the FIFO is simply emptied.
  assign pop  = inst_valid && bus.Inst_Ready && !bus.Redirect_Valid;
  assign push = (state_q == REQ) && bus.Imem_Ack && !bus.Redirect_Valid;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;

    if (bus.Redirect_Valid) begin
      pc_d     = {bus.Redirect_PC[31:2], 2'b00};
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else if (push) begin
      pc_d = pc_q + 32'd4;
    end

    // A request only starts when a slot is already reserved for its data.
    unique case (state_q)
      IDLE: begin
        if (count_d < CW'(FIFO_DEPTH)) state_d = REQ;
      end
      REQ: begin
        if (bus.Imem_Ack) state_d = (count_d < CW'(FIFO_DEPTH)) ? REQ : IDLE;
        else if (bus.Redirect_Valid) state_d = DISCARD;
      end
      DISCARD: begin
        if (bus.Imem_Ack) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase

    addr_d = (state_d == REQ) ? pc_d : addr_q;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      addr_q   <= RESET_PC;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= pc_q;
      data_mem[wr_ptr_q] <= bus.Imem_Data;
    end
  end

  assign bus.Imem_Req   = (state_q != IDLE);
  assign bus.Imem_Addr  = addr_q;
  assign bus.Inst_Valid = inst_valid;
  assign bus.Inst_Out   = inst_valid ? data_mem[rd_ptr_q] : NOP;
  assign bus.Inst_PC    = inst_valid ? pc_mem[rd_ptr_q] : 32'h0;
  assign dbg_state_o    = state_q;

`ifdef IFU_PERF_EN
  logic [31:0] fetch_cnt_q, flush_cnt_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (pop)                fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (bus.Redirect_Valid) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign Fetch_Count = fetch_cnt_q;
  assign Flush_Count = flush_cnt_q;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed and randomized bench for instr_fetch_unit; the reference model tracks
// the expected in-order PC stream from the last reset or redirect target.
module tb_instr_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  instr_fetch_unit_if bus ();
  logic [1:0] unused_dbg_state;
`ifdef IFU_PERF_EN
  logic [31:0] fetch_count, flush_count;
`endif

  instr_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(4)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .bus         (bus.master),
    .dbg_state_o (unused_dbg_state)
`ifdef IFU_PERF_EN
    ,.Fetch_Count (fetch_count)
    ,.Flush_Count (flush_count)
`endif
  );

  int          total = 0;
  int          bad   = 0;
  int          pops, flushes, acks;
  logic [31:0] exp_pc;
  logic [31:0] data_xor;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check pop against the model, advance, check after edge.
  task automatic cycle(input logic rdy, input logic redir, input logic [31:0] rpc, input logic ack);
    logic        pre_req, pre_valid;
    logic [31:0] pre_addr, exp_head;
    pre_req   = bus.Imem_Req;
    pre_addr  = bus.Imem_Addr;
    pre_valid = bus.Inst_Valid;
    if (!pre_valid) chk("nop_when_empty", bus.Inst_Out, NOP);
    bus.Inst_Ready     = rdy;
    bus.Redirect_Valid = redir;
    bus.Redirect_PC    = rpc;
    bus.Imem_Ack       = ack;
    bus.Imem_Data      = pre_addr ^ data_xor;
    if (pre_valid && rdy && !redir) begin
      exp_q.push_back(exp_pc);
      exp_head = exp_q.pop_front();
      chk("head_pc", bus.Inst_PC, exp_head);
      chk("head_data", bus.Inst_Out, exp_head ^ data_xor);
      exp_pc = exp_pc + 32'd4;
      pops++;
    end
    if (pre_req && ack) acks++;
    @(posedge Clk);
    #1;
    if (redir) begin
      exp_pc = {rpc[31:2], 2'b00};
      flushes++;
      chk("flush_valid", 32'(bus.Inst_Valid), 32'd0);
    end
    if (pre_req && !ack) begin
      chk("req_held", 32'(bus.Imem_Req), 32'd1);
      chk("addr_held", bus.Imem_Addr, pre_addr);
    end
    bus.Imem_Ack       = 1'b0;
    bus.Redirect_Valid = 1'b0;
  endtask

  task automatic do_reset();
    bus.Inst_Ready     = 1'b0;
    bus.Redirect_Valid = 1'b0;
    bus.Redirect_PC    = 32'h0;
    bus.Imem_Ack       = 1'b0;
    bus.Imem_Data      = 32'h0;
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    Reset   = 1'b0;
    exp_pc  = RESET_PC;
    pops    = 0;
    flushes = 0;
    acks    = 0;
  endtask

  initial begin
    int p0;
    data_xor = 32'h0;
    Reset = 1'b1;
    bus.Inst_Ready = 1'b0; bus.Redirect_Valid = 1'b0; bus.Redirect_PC = 32'h0;
    bus.Imem_Ack = 1'b0;   bus.Imem_Data = 32'h0;
    #3;
    chk("rst_req", 32'(bus.Imem_Req), 32'd0);
    chk("rst_addr", bus.Imem_Addr, RESET_PC);
    chk("rst_valid", 32'(bus.Inst_Valid), 32'd0);
    chk("rst_out", bus.Inst_Out, NOP);
    chk("rst_pc", bus.Inst_PC, 32'h0);

    // Reset release, memory acks every cycle with data = address
    do_reset();
    chk("idle_after_release", 32'(bus.Imem_Req), 32'd0);
    @(posedge Clk); #1;
    chk("first_req", 32'(bus.Imem_Req), 32'd1);
    chk("first_addr", bus.Imem_Addr, RESET_PC);
    for (int i = 0; i < 6; i++) begin
      chk("addr_seq", bus.Imem_Addr, 32'(i * 4));
      cycle(1'b1, 1'b0, 32'h0, 1'b1);
      if (i == 0) begin
        chk("ack_to_valid", 32'(bus.Inst_Valid), 32'd1);
        chk("first_head_pc", bus.Inst_PC, 32'h0);
      end
    end

    // Decode stalled: exactly four acks fill the FIFO, then requests stop
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("fill_acks", 32'(acks), 32'd4);
    chk("full_no_req", 32'(bus.Imem_Req), 32'd0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    chk("refill_req", 32'(bus.Imem_Req), 32'd1);
    chk("refill_addr", bus.Imem_Addr, 32'h10);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0, 1'b0);

    // Redirect while a request is outstanding; stale ack arrives 3 cycles later
    do_reset();
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("pre_redirect_addr", bus.Imem_Addr, 32'h8);
    cycle(1'b0, 1'b1, 32'h0000_0103, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("after_stale_req", 32'(bus.Imem_Req), 32'd1);
    chk("after_stale_addr", bus.Imem_Addr, 32'h100);
    chk("stale_dropped", 32'(bus.Inst_Valid), 32'd0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("redir_head_pc", bus.Inst_PC, 32'h100);
    cycle(1'b1, 1'b0, 32'h0, 1'b0);

    // Redirect and ack in the same cycle with two entries buffered
    do_reset();
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b1, 32'h0000_0200, 1'b1);
    chk("same_cycle_req", 32'(bus.Imem_Req), 32'd1);
    chk("same_cycle_addr", bus.Imem_Addr, 32'h200);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("same_cycle_head", bus.Inst_PC, 32'h200);
    cycle(1'b1, 1'b0, 32'h0, 1'b0);

    // Fetch PC wrap at the top of the address space
    cycle(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
    chk("wrap_top_addr", bus.Imem_Addr, 32'hFFFF_FFFC);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("wrap_addr", bus.Imem_Addr, 32'h0);
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b0);

    // Redirect with no request outstanding reaches Imem_Addr in one cycle
    do_reset();
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("idle_full", 32'(bus.Imem_Req), 32'd0);
    cycle(1'b0, 1'b1, 32'h0000_0300, 1'b0);
    chk("idle_redir_req", 32'(bus.Imem_Req), 32'd1);
    chk("idle_redir_addr", bus.Imem_Addr, 32'h300);

    // Reset asserted mid-transaction, with a stale ack during reset
    Reset = 1'b1;
    #2;
    chk("async_req", 32'(bus.Imem_Req), 32'd0);
    chk("async_addr", bus.Imem_Addr, RESET_PC);
    chk("async_valid", 32'(bus.Inst_Valid), 32'd0);
    chk("async_out", bus.Inst_Out, NOP);
    chk("async_pc", bus.Inst_PC, 32'h0);
`ifdef IFU_PERF_EN
    chk("perf_fetch_rst", fetch_count, 32'h0);
    chk("perf_flush_rst", flush_count, 32'h0);
`endif
    bus.Imem_Ack = 1'b1;
    @(posedge Clk); #1;
    bus.Imem_Ack = 1'b0;
    Reset = 1'b0;
    exp_pc = RESET_PC; pops = 0; flushes = 0; acks = 0;
    @(posedge Clk); #1;
    chk("post_rst_req", 32'(bus.Imem_Req), 32'd1);
    chk("post_rst_addr", bus.Imem_Addr, RESET_PC);

    // Randomized traffic against the PC-stream model
    data_xor = $urandom;
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 40) == 0),
            $urandom, ($urandom_range(0, 2) != 0));
    end
    p0 = pops;
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1);
    chk("throughput", 32'((pops - p0) >= 15), 32'd1);
`ifdef IFU_PERF_EN
    chk("perf_fetch", fetch_count, 32'(pops));
    chk("perf_flush", flush_count, 32'(flushes));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
